// File: rtl/i2c_slave.sv
// Byte-level I2C target: oversamples scl/sda, acknowledges ADDR, hands written
// bytes out on rx_data and serves read bytes from tx_data via an open-drain sda_oe.
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  scl_sync_q, scl_sync_d;
  logic [2:0]  sda_sync_q, sda_sync_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [6:0]  tx_shift_q, tx_shift_d;
  logic        ack_q, ack_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_req_q, tx_req_d;

  logic scl_lvl, scl_prev, sda_lvl, sda_prev;
  logic scl_rise, scl_fall, start_ev, stop_ev, addr_hit;

  // bits [1:0] are the two-flop synchronizer, bit 2 is the edge-history flop
  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl_in};
    sda_sync_d = {sda_sync_q[1:0], sda_in};
  end

  always_comb begin
    scl_lvl  = scl_sync_q[1];
    scl_prev = scl_sync_q[2];
    sda_lvl  = sda_sync_q[1];
    sda_prev = sda_sync_q[2];
    scl_rise = scl_lvl & ~scl_prev;
    scl_fall = ~scl_lvl & scl_prev;
    start_ev = scl_lvl & scl_prev & sda_prev & ~sda_lvl;
    stop_ev  = scl_lvl & scl_prev & ~sda_prev & sda_lvl;
    addr_hit = (shift_q[7:1] == ADDR);
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ack_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
    end
  end

  // read-byte shifter is pure data; it is always reloaded before use
  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    if (stop_ev) begin
      state_d = S_IDLE;
    end else if (start_ev) begin
      state_d = S_ADDR;
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR:     if (cnt_q == 4'd8) state_d = addr_hit ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: state_d = shift_q[0] ? S_RD : S_WR;
        S_WR:       if (cnt_q == 4'd8) state_d = S_WR_ACK;
        S_WR_ACK:   state_d = S_WR;
        S_RD:       if (cnt_q == 4'd8) state_d = S_RD_ACK;
        S_RD_ACK:   state_d = ack_q ? S_IGNORE : S_RD;
        default:    state_d = state_q;
      endcase
    end
  end

  // ---- output / datapath logic ----
  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    ack_d      = ack_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;

    if (stop_ev) begin
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_ev) begin
      // repeated START keeps busy until the new address proves foreign
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      if (scl_rise) begin
        case (state_q)
          S_ADDR, S_WR: begin
            if (cnt_q != 4'd8) begin
              shift_d = {shift_q[6:0], sda_lvl};
              cnt_d   = cnt_q + 4'd1;
            end
          end
          S_RD_ACK: ack_d = sda_lvl;
          default:  ack_d = ack_q;
        endcase
      end

      if (scl_fall) begin
        case (state_q)
          S_ADDR: begin
            if (cnt_q == 4'd8) begin
              cnt_d    = 4'd0;
              sda_oe_d = addr_hit;
              busy_d   = addr_hit;
            end
          end
          S_ADDR_ACK: begin
            if (shift_q[0]) begin
              tx_shift_d = tx_data[6:0];
              tx_req_d   = 1'b1;
              sda_oe_d   = ~tx_data[7];
              cnt_d      = 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
            end
          end
          S_WR: begin
            if (cnt_q == 4'd8) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              cnt_d      = 4'd0;
            end
          end
          S_WR_ACK: begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
          end
          S_RD: begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
              cnt_d      = cnt_q + 4'd1;
            end
          end
          S_RD_ACK: begin
            if (!ack_q) begin
              tx_shift_d = tx_data[6:0];
              tx_req_d   = 1'b1;
              sda_oe_d   = ~tx_data[7];
              cnt_d      = 4'd1;
            end else begin
              sda_oe_d = 1'b0;
            end
          end
          S_IGNORE: begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
          end
          default: sda_oe_d = sda_oe_q;
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a timed I2C master model drives transactions; expected
// write bytes and read requests go into queues checked by an output monitor.
module tb_i2c_slave;

  localparam logic [6:0] ADDR = 7'h3C;
  localparam int H = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data, tx_data;

  int checks = 0;
  int failures = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  bit last_stopped = 1'b1;

  logic [7:0] exp_rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] cur_bytes[$];

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave #(.ADDR(ADDR)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // output monitor / scoreboard
  always @(negedge clk) begin
    if (sda_oe === 1'b1) oe_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (rx_valid === 1'b1 || tx_req === 1'b1)
      chk("pulse_overlap", {31'd0, rx_valid & tx_req}, 0);
    if (rx_valid === 1'b1) begin
      if (exp_rx_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rx_valid actual=%0h required=none", rx_data);
      end else begin
        logic [7:0] e;
        e = exp_rx_q.pop_front();
        chk("rx_data", rx_data, e);
      end
    end
    if (tx_req === 1'b1) begin
      checks++;
      if (tx_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tx_req actual=1 required=0");
      end else begin
        void'(tx_q.pop_front());
      end
    end else begin
      tx_data = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
  end

  task automatic hw(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic bout, output logic bin, output logic oe_mid);
    sda_m = bout;
    hw(H - 2);
    scl_m = 1'b1;
    hw(H / 2);
    bin = sda_bus;
    oe_mid = sda_oe;
    hw(H / 2);
    scl_m = 1'b0;
    hw(2);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; hw(H);
    scl_m = 1'b1; hw(H);
    sda_m = 1'b0; hw(H);
    scl_m = 1'b0; hw(2);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; hw(H);
    scl_m = 1'b1; hw(H);
    sda_m = 1'b1; hw(4);
    chk("busy_after_stop", {31'd0, busy}, 0);
    hw(H - 4);
    last_stopped = 1'b1;
  endtask

  task automatic write_bits(input logic [7:0] b, input int n);
    logic bi, oe;
    for (int i = 0; i < n; i++) clock_bit(b[7-i], bi, oe);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic oe;
    write_bits(b, 8);
    clock_bit(1'b1, ack, oe);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d, output logic oe_ack);
    logic bi, oe, dummy;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, bi, oe);
      d[7-i] = bi;
    end
    clock_bit(nack, dummy, oe_ack);
    sda_m = 1'b1;
  endtask

  // reference model: a target at ADDR ACKs its address and every written
  // byte, reports written bytes, and returns queued bytes on reads; any other
  // address leaves the bus untouched.
  task automatic xfer(input logic [6:0] a, input logic rw, input bit do_stop);
    bit         hit;
    bit         fresh;
    logic       ack, oe_ack;
    logic [7:0] got;
    int         oe0, b0;
    hit = (a == ADDR);
    fresh = last_stopped;
    if (hit && rw) foreach (cur_bytes[i]) tx_q.push_back(cur_bytes[i]);
    bus_start();
    last_stopped = 1'b0;
    oe0 = oe_cnt;
    b0 = busy_cnt;
    write_byte({a, rw}, ack);
    chk("addr_ack", {31'd0, ack}, hit ? 0 : 1);
    chk("busy_after_addr", {31'd0, busy}, hit ? 1 : 0);
    for (int i = 0; i < cur_bytes.size(); i++) begin
      if (!rw) begin
        if (hit) exp_rx_q.push_back(cur_bytes[i]);
        write_byte(cur_bytes[i], ack);
        chk("wr_ack", {31'd0, ack}, hit ? 0 : 1);
      end else begin
        read_byte(i == cur_bytes.size() - 1, got, oe_ack);
        chk("rd_byte", got, hit ? cur_bytes[i] : 8'hFF);
        chk("rd_ack_released", {31'd0, oe_ack}, 0);
      end
    end
    if (!hit) begin
      chk("miss_no_oe", oe_cnt - oe0, 0);
      if (fresh) chk("miss_no_busy", busy_cnt - b0, 0);
    end
    if (do_stop) bus_stop();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic ack;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    hw(4);
    rst = 1'b0;
    hw(1);
    chk("rst_sda_oe", {31'd0, sda_oe}, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_tx_req", {31'd0, tx_req}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    hw(H);

    // write 0xA5
    cur_bytes = '{8'hA5};
    xfer(ADDR, 1'b0, 1'b1);
    // address miss 0xA0 then 0x11
    cur_bytes = '{8'h11};
    xfer(7'h50, 1'b0, 1'b1);
    // single read with NACK
    cur_bytes = '{8'h5A};
    xfer(ADDR, 1'b1, 1'b1);
    // two-byte read, first byte ACKed
    cur_bytes = '{8'h5A, 8'hC3};
    xfer(ADDR, 1'b1, 1'b1);
    // write then repeated START into a read
    cur_bytes = '{8'h0F};
    xfer(ADDR, 1'b0, 1'b0);
    cur_bytes = '{8'h96};
    xfer(ADDR, 1'b1, 1'b1);
    chk("rx_data_hold", rx_data, 8'h0F);

    // STOP after four data bits: partial byte discarded
    bus_start();
    write_byte({ADDR, 1'b0}, ack);
    chk("partial_addr_ack", {31'd0, ack}, 0);
    write_bits(8'hF0, 4);
    bus_stop();
    chk("partial_oe_released", {31'd0, sda_oe}, 0);

    // reset while the address ACK is being driven
    bus_start();
    write_bits({ADDR, 1'b0}, 8);
    sda_m = 1'b1;
    hw(H - 2);
    chk("oe_in_ack", {31'd0, sda_oe}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("oe_after_rst", {31'd0, sda_oe}, 0);
    rst = 1'b0;
    scl_m = 1'b1; hw(H);
    scl_m = 1'b0; hw(2);
    bus_stop();
    cur_bytes = '{8'h3E, 8'h81};
    xfer(ADDR, 1'b0, 1'b1);

    // randomized transactions, some chained with repeated START
    for (int k = 0; k < 20; k++) begin
      logic [6:0] a;
      logic       rw;
      int         n;
      bit         st;
      if ($urandom_range(0, 2) != 0) a = ADDR;
      else begin
        a = 7'($urandom_range(0, 127));
        if (a == ADDR) a = a ^ 7'h01;
      end
      rw = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      cur_bytes = {};
      for (int j = 0; j < n; j++) cur_bytes.push_back(8'($urandom_range(0, 255)));
      st = (k == 19) || ($urandom_range(0, 3) != 0);
      xfer(a, rw, st);
    end

    hw(8);
    chk("rx_queue_drained", exp_rx_q.size(), 0);
    chk("tx_queue_drained", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
